alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational ALU.
- Accepts one operation per transaction over a valid/ready handshake.
- Simple ops complete in 1 cycle; multiply, divide and remainder run iteratively over N cycles.
- Adds remainder, arithmetic shift right, registered result with backpressure, and status flags; sits between a register-file read stage and write-back.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept a new operation
- a  input  N  operand A
- b  input  N  operand B / shift amount
- operation  input  4  opcode (see Behaviour)
- sign  input  1  1 = signed (two's complement) semantics, 0 = unsigned
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  N  registered result
- flags  output  4  {Z, NEG, V, DZ}

Behaviour:
- Reset: asynchronous on rst_n low; state=IDLE, in_ready=0 while asserted, out_valid=0, result=0, flags=0.
- After release, in_ready=1 from the first clock.
- Reset mid-operation discards the in-flight op.
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures a, b, operation, sign, then goes to EXEC (MUL/DIV/REM with b!=0 for DIV/REM) or DONE (all other ops).
  - EXEC: iteration counter runs N cycles, then goes to DONE.
  - DONE: out_valid=1 with result/flags held stable until out_ready; on out_valid&out_ready returns to IDLE.
- in_ready=0 outside IDLE; one op in flight.
- Latency, accept edge to out_valid: 1 cycle for single-cycle ops and divide-by-zero; N+1 cycles for MUL/DIV/REM.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL (low N bits), 0011 DIV (quotient), 0100 AND, 0101 OR, 0110 NOT a
  - 0111 LSL by b, 1000 LSR by b, 1001 ASR by b, 1010 REM
  - 1011-1111 illegal: result=0, Z=1, other flags 0.
- MUL: shift-add over N cycles on a 2N-bit accumulator.
  - Signed: operands converted to magnitudes, product negated if signs differ.
- DIV/REM: restoring division, one quotient bit per cycle, on magnitudes.
  - Signed: truncation toward zero; quotient negated if signs differ; remainder takes the dividend's sign.
- Shifts: amount is b as unsigned.
  - If b >= N: LSL/LSR give 0; ASR gives N copies of a[N-1] when sign=1, else 0.
  - ASR with sign=0 behaves as LSR.
- Flags:
  - Z: result==0.
  - NEG: result[N-1] when sign=1, else 0.
  - V, ADD/SUB: signed overflow (sign=1), or carry-out / borrow (sign=0).
  - V, MUL: full 2N-bit product not representable in N bits.
  - V, DIV: signed -2^(N-1) / -1; quotient wraps to -2^(N-1), remainder 0.
  - V: 0 for all other ops.
  - DZ: DIV/REM with b==0. DIV returns all ones; REM returns a; V=0.
- Simultaneous out_ready in DONE and in_valid: the new op is not accepted that cycle; it is accepted the next cycle in IDLE.

Optional Feature:
- Macro ALU_SEQ_FAST_MUL_EN.
- Defined: MUL completes in 1 cycle using a combinational N x N multiplier. Latency = 1 and no EXEC state is used for MUL; flags are identical.
- Undefined: iterative N-cycle MUL as above.
- DIV/REM are iterative in both builds.

Test Plan:
- N=8, sign=1, ADD a=8'h7F b=8'h01 -> result 8'h80, flags Z=0 NEG=1 V=1 DZ=0, out_valid 1 cycle after accept.
- N=8, sign=1, MUL a=8'hFD (-3) b=8'h05 -> result 8'hF1 (-15), V=0, out_valid exactly 9 cycles after accept (1 cycle if ALU_SEQ_FAST_MUL_EN).
- N=8, sign=1, DIV a=8'hF9 (-7) b=8'h02 -> 8'hFD. REM same operands -> 8'hFF. Unsigned DIV 8'h64/8'h07 -> 8'h0E; REM -> 8'h02.
- N=8, DIV a=8'h25 b=8'h00 -> result 8'hFF, DZ=1, latency 1. REM a=8'h25 b=0 -> 8'h25, DZ=1.
- Hold out_ready=0 for 4 cycles after out_valid -> result/flags stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 next cycle.
- Assert rst_n=0 in cycle 3 of an 8-bit MUL -> out_valid=0, result=0 immediately. After release, in_ready=1 and the next op returns a correct result.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake bundle between the issue stage, alu_seq and write-back.
// The master side presents operations and consumes results; alu_seq is the slave.
interface alu_seq_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   operation;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, operation, sign, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, operation, sign, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked N-bit ALU, one operation in flight, valid/ready on both sides.
// Simple ops finish in one cycle; MUL (shift-add), DIV and REM (restoring
// division) iterate for N cycles on operand magnitudes, then fix up the signs.
// Result and flags {Z, NEG, V, DZ} are registered and held until out_ready.
// Optional build macro ALU_SEQ_FAST_MUL_EN: MUL uses a combinational N x N
// multiplier and completes in one cycle; DIV/REM stay iterative.
module alu_seq #(
  parameter int N = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int             CW       = $clog2(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [N:0]     N_AMT    = (N + 1)'(N);
  localparam logic [N-1:0]   MIN_NEG  = {1'b1, {(N - 1){1'b0}}};

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_LSL = 4'b0111;
  localparam logic [3:0] OP_LSR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t         state;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [N-1:0]   result_q;
  logic [3:0]     flags_q;
  logic [3:0]     op_r;
  logic           sign_r;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;   // MUL: {partial sum, multiplier}; DIV/REM: {remainder, quotient}

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic s);
    return (s && x[N-1]) ? -x : x;
  endfunction

  function automatic logic [2*N-1:0] fix_prod(input logic [2*N-1:0] p, input logic n);
    return n ? -p : p;
  endfunction

  // Signed: the top N+1 bits must be a pure sign extension. Unsigned: top N bits zero.
  function automatic logic mul_ovf(input logic [2*N-1:0] p, input logic s);
    if (s) return !((&p[2*N-1:N-1]) || !(|p[2*N-1:N-1]));
    return |p[2*N-1:N];
  endfunction

  function automatic logic [3:0] mk_flags(input logic [N-1:0] r, input logic s,
                                          input logic v, input logic dz);
    return {r == '0, s & r[N-1], v, dz};
  endfunction

  // Accept-side decode: which ops need the iterative datapath.
  logic         iter_op;
  logic [N-1:0] mag_a_in;
  logic [N-1:0] mag_b_in;

  assign mag_a_in = mag(bus.a, bus.sign);
  assign mag_b_in = mag(bus.b, bus.sign);

`ifdef ALU_SEQ_FAST_MUL_EN
  assign iter_op = ((bus.operation == OP_DIV) || (bus.operation == OP_REM)) && (bus.b != '0);

  logic [2*N-1:0] fast_full;
  assign fast_full = fix_prod({{N{1'b0}}, mag_a_in} * {{N{1'b0}}, mag_b_in},
                              bus.sign & (bus.a[N-1] ^ bus.b[N-1]));
`else
  assign iter_op = (bus.operation == OP_MUL) ||
                   (((bus.operation == OP_DIV) || (bus.operation == OP_REM)) && (bus.b != '0));
`endif

  // Single-cycle results, computed straight from the presented operands.
  logic [N:0]   add_w;
  logic [N:0]   sub_w;
  logic [N-1:0] sc_res;
  logic         sc_v;
  logic         sc_dz;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    add_w  = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
    sc_res = '0;
    sc_v   = 1'b0;
    sc_dz  = 1'b0;
    case (bus.operation)
      OP_ADD: begin
        sc_res = add_w[N-1:0];
        sc_v   = bus.sign ? ((bus.a[N-1] == bus.b[N-1]) && (add_w[N-1] != bus.a[N-1]))
                          : add_w[N];
      end
      OP_SUB: begin
        sc_res = sub_w[N-1:0];
        sc_v   = bus.sign ? ((bus.a[N-1] != bus.b[N-1]) && (sub_w[N-1] != bus.a[N-1]))
                          : sub_w[N];
      end
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_NOT: sc_res = ~bus.a;
      OP_LSL: sc_res = ({1'b0, bus.b} >= N_AMT) ? '0 : bus.a << bus.b;
      OP_LSR: sc_res = ({1'b0, bus.b} >= N_AMT) ? '0 : bus.a >> bus.b;
      OP_ASR: begin
        // NOTE: kept as if/else: inside a ?: with an unsigned arm, >>> would silently become a logical shift.
        if ({1'b0, bus.b} >= N_AMT)
          sc_res = bus.sign ? {N{bus.a[N-1]}} : '0;
        else if (bus.sign)
          sc_res = $signed(bus.a) >>> bus.b;
        else
          sc_res = bus.a >> bus.b;
      end
      // Only reached with b == 0; nonzero divisors go through the iterative path.
      OP_DIV: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_REM: begin
        sc_res = bus.a;
        sc_dz  = 1'b1;
      end
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL: begin
        sc_res = fast_full[N-1:0];
        sc_v   = mul_ovf(fast_full, bus.sign);
      end
`endif
      default: ;  // illegal opcodes: result 0, Z set by mk_flags
    endcase
  end

  // One iteration step of shift-add multiply or restoring divide, plus sign fix-up
  // of the value that step produces (used on the final iteration).
  logic [N-1:0]   mag_a_r;
  logic [N-1:0]   mag_b_r;
  logic [N:0]     mul_sum;
  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic [2*N-1:0] acc_next;
  logic [2*N-1:0] mul_full;
  logic [N-1:0]   fin_res;
  logic           fin_v;

  assign mag_a_r = mag(a_r, sign_r);
  assign mag_b_r = mag(b_r, sign_r);

  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mag_a_r} : '0);
    div_shift = {acc[2*N-1:N], acc[N-1]};
    div_diff  = div_shift - {1'b0, mag_b_r};
    if (op_r == OP_MUL)
      acc_next = {mul_sum, acc[N-1:1]};
    else if (!div_diff[N])
      acc_next = {div_diff[N-1:0], acc[N-2:0], 1'b1};
    else
      acc_next = {div_shift[N-1:0], acc[N-2:0], 1'b0};

    mul_full = fix_prod(acc_next, sign_r & (a_r[N-1] ^ b_r[N-1]));
    fin_v    = 1'b0;
    case (op_r)
      OP_MUL: begin
        fin_res = mul_full[N-1:0];
        fin_v   = mul_ovf(mul_full, sign_r);
      end
      OP_DIV: begin
        // -2^(N-1) / -1: magnitude quotient 2^(N-1) is not negated, so it wraps naturally.
        fin_res = (sign_r && (a_r[N-1] ^ b_r[N-1])) ? -acc_next[N-1:0] : acc_next[N-1:0];
        fin_v   = sign_r && (a_r == MIN_NEG) && (b_r == '1);
      end
      default: fin_res = (sign_r && a_r[N-1]) ? -acc_next[2*N-1:N] : acc_next[2*N-1:N];
    endcase
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      op_r        <= '0;
      sign_r      <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            op_r       <= bus.operation;
            sign_r     <= bus.sign;
            a_r        <= bus.a;
            b_r        <= bus.b;
            in_ready_q <= 1'b0;
            if (iter_op) begin
              state <= S_EXEC;
              cnt   <= '0;
              acc   <= (bus.operation == OP_MUL) ? {{N{1'b0}}, mag_b_in} : {{N{1'b0}}, mag_a_in};
            end else begin
              state       <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= sc_res;
              flags_q     <= mk_flags(sc_res, bus.sign, sc_v, sc_dz);
            end
          end
        end
        S_EXEC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= fin_res;
            flags_q     <= mk_flags(fin_res, sign_r, fin_v, 1'b0);
          end
        end
        S_DONE: begin
          // in_ready stays low here, so an op presented alongside out_ready waits a cycle.
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at N=8.
module tb_alu_seq;

  localparam int N = 8;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = N + 1;
`endif
  localparam int ITER_LAT = N + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_LSL = 4'b0111;
  localparam logic [3:0] OP_LSR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;
  localparam logic [3:0] OP_BAD = 4'b1100;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  int   lat;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present an op, wait (bounded) for in_ready, return #1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic s);
    int guard = 0;
    bus.operation = op;
    bus.a         = av;
    bus.b         = bv;
    bus.sign      = s;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen; 1 means right after it.
  task automatic wait_out();
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] av,
                     input logic [7:0] bv, input logic s, input logic [7:0] er,
                     input logic [3:0] ef, input int el);
    issue(op, av, bv, s);
    wait_out();
    check({tag, " latency"}, lat, el);
    check({tag, " result"}, bus.result, er);
    check({tag, " flags"}, bus.flags, ef);
    pop();
    check({tag, " in_ready after pop"}, bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.operation = '0;
    bus.sign      = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset result", bus.result, 0);
    check("reset flags", bus.flags, 0);
    @(posedge clk); #1;
    check("reset in_ready held", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready first clock", bus.in_ready, 1);

    // flags = {Z, NEG, V, DZ}
    run("add s ovf",   OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0110, 1);
    run("add u carry", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010, 1);
    run("sub u borrow",OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 4'b0010, 1);
    run("mul s",       OP_MUL, 8'hFD, 8'h05, 1'b1, 8'hF1, 4'b0100, MUL_LAT);
    run("mul u ovf",   OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 4'b1010, MUL_LAT);
    run("div s",       OP_DIV, 8'hF9, 8'h02, 1'b1, 8'hFD, 4'b0100, ITER_LAT);
    run("rem s",       OP_REM, 8'hF9, 8'h02, 1'b1, 8'hFF, 4'b0100, ITER_LAT);
    run("div u",       OP_DIV, 8'h64, 8'h07, 1'b0, 8'h0E, 4'b0000, ITER_LAT);
    run("rem u",       OP_REM, 8'h64, 8'h07, 1'b0, 8'h02, 4'b0000, ITER_LAT);
    run("div s ovf",   OP_DIV, 8'h80, 8'hFF, 1'b1, 8'h80, 4'b0110, ITER_LAT);
    run("div by 0",    OP_DIV, 8'h25, 8'h00, 1'b0, 8'hFF, 4'b0001, 1);
    run("rem by 0",    OP_REM, 8'h25, 8'h00, 1'b0, 8'h25, 4'b0001, 1);
    run("asr s 2",     OP_ASR, 8'h80, 8'h02, 1'b1, 8'hE0, 4'b0100, 1);
    run("asr s 9",     OP_ASR, 8'h80, 8'h09, 1'b1, 8'hFF, 4'b0100, 1);
    run("asr u 2",     OP_ASR, 8'h80, 8'h02, 1'b0, 8'h20, 4'b0000, 1);
    run("lsl 1",       OP_LSL, 8'h81, 8'h01, 1'b0, 8'h02, 4'b0000, 1);
    run("lsr 8",       OP_LSR, 8'h80, 8'h08, 1'b0, 8'h00, 4'b1000, 1);
    run("not",         OP_NOT, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0000, 1);
    run("or s",        OP_OR,  8'h0F, 8'hF0, 1'b1, 8'hFF, 4'b0100, 1);
    run("illegal",     OP_BAD, 8'h12, 8'h34, 1'b1, 8'h00, 4'b1000, 1);

    // Backpressure: result held while out_ready is low; a pending op is ignored.
    issue(OP_ADD, 8'h01, 8'h02, 1'b0);
    bus.operation = OP_SUB;
    bus.a         = 8'h05;
    bus.b         = 8'h01;
    bus.sign      = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("hold out_valid", bus.out_valid, 1);
      check("hold result", bus.result, 8'h03);
      check("hold flags", bus.flags, 4'b0000);
      check("hold in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release in_ready", bus.in_ready, 1);
    check("release out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pending op out_valid", bus.out_valid, 1);
    check("pending op result", bus.result, 8'h04);
    pop();

    // Reset in cycle 3 of a MUL drops it immediately.
    issue(OP_MUL, 8'h03, 8'h04, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", bus.out_valid, 0);
    check("midreset result", bus.result, 0);
    check("midreset in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post reset in_ready", bus.in_ready, 1);
    check("post reset out_valid", bus.out_valid, 0);
    run("mul after reset", OP_MUL, 8'h03, 8'h04, 1'b1, 8'h0C, 4'b0000, MUL_LAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
